// File: rtl/cell_store.sv
// ---------------------------------------------------------------------------
// cell_store
//
// Dual-bank cell memory for the evolution engine. The current bank holds
// generation g and the next bank collects generation g+1. The current
// bank has one read port, shared by the evolution engine and the display
// scanner. A user load port writes the current bank while idle, and a
// clear sequencer zeroes both banks one cell per cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   evo_rden, evo_read_pos     evolution read (current bank); copy source
//   prev_status                evolution read data, 1-cycle latency
//   evo_wden, evo_write_pos    evolution write (next bank); copy destination
//   live                       evolution write data
//   copy_rden, copy_wden       copy sweep strobes (next -> current)
//   disp_rden, disp_pos        display read request
//   disp_data, disp_valid      display read data / grant flag
//   load_en, load_pos, load_data  user write to the current bank (idle only)
//   clear_req                  pulse: zero both banks
//   busy                       generation or clear in progress
//   live_count                 number of live cells in the current bank
//
// Optional feature: define CELL_STORE_POPCOUNT_EN to build the live-cell
// counter; otherwise live_count is tied to zero.
// ---------------------------------------------------------------------------
module cell_store #(
    parameter int P_PARAM_M = 5,
    parameter int P_PARAM_N = 5,
    parameter int WIDTH     = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               evo_rden,
    input  logic [2*WIDTH-1:0] evo_read_pos,
    output logic               prev_status,
    input  logic               evo_wden,
    input  logic [2*WIDTH-1:0] evo_write_pos,
    input  logic               live,
    input  logic               copy_rden,
    input  logic               copy_wden,
    input  logic               disp_rden,
    input  logic [2*WIDTH-1:0] disp_pos,
    output logic               disp_data,
    output logic               disp_valid,
    input  logic               load_en,
    input  logic [2*WIDTH-1:0] load_pos,
    input  logic               load_data,
    input  logic               clear_req,
    output logic               busy,
    output logic [2*WIDTH-1:0] live_count
);

    localparam int AW    = 2 * WIDTH;
    localparam int CELLS = P_PARAM_M * P_PARAM_N;
    localparam int CW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [AW-1:0] CELLS_A  = AW'(CELLS);
    localparam logic [CW-1:0] LAST_IDX = CW'(CELLS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVOLVE,
        S_COPY,
        S_CLEAR
    } state_t;

    state_t           state;
    logic [CELLS-1:0] cur_bank;
    logic [CELLS-1:0] nxt_bank;
    logic             copy_buf;
    logic             strobe_d;
    logic [CW-1:0]    clr_idx;

    // Address decode: out-of-range addresses read as 0 and drop writes.
    logic          evo_rd_ok, evo_wr_ok, disp_ok, load_ok;
    logic [CW-1:0] evo_rd_idx, evo_wr_idx, disp_idx, load_idx;

    assign evo_rd_ok  = (evo_read_pos  < CELLS_A);
    assign evo_wr_ok  = (evo_write_pos < CELLS_A);
    assign disp_ok    = (disp_pos      < CELLS_A);
    assign load_ok    = (load_pos      < CELLS_A);
    assign evo_rd_idx = evo_read_pos[CW-1:0];
    assign evo_wr_idx = evo_write_pos[CW-1:0];
    assign disp_idx   = disp_pos[CW-1:0];
    assign load_idx   = load_pos[CW-1:0];

    // Current-bank write mux: load (idle), copy (copy), clear (clear).
    logic          strobes;
    logic          evo_grant;
    logic          copy_wr;
    logic          cur_we;
    logic [CW-1:0] cur_widx;
    logic          cur_wbit;

    always_comb begin
        strobes   = copy_rden && copy_wden;
        evo_grant = evo_rden && ((state == S_IDLE) || (state == S_EVOLVE));
        // The copy write lags the copy read by one cycle, so it only fires
        // once the strobes have been high for two consecutive cycles.
        copy_wr   = (state == S_COPY) && strobes && strobe_d;
        cur_we    = 1'b0;
        cur_widx  = load_idx;
        cur_wbit  = load_data;
        case (state)
            S_IDLE: begin
                if (load_en && load_ok) begin
                    cur_we   = 1'b1;
                    cur_widx = load_idx;
                    cur_wbit = load_data;
                end
            end
            S_COPY: begin
                if (copy_wr && evo_wr_ok) begin
                    cur_we   = 1'b1;
                    cur_widx = evo_wr_idx;
                    cur_wbit = copy_buf;
                end
            end
            S_CLEAR: begin
                cur_we   = 1'b1;
                cur_widx = clr_idx;
                cur_wbit = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur_bank    <= '0;
            nxt_bank    <= '0;
            copy_buf    <= 1'b0;
            strobe_d    <= 1'b0;
            clr_idx     <= '0;
            prev_status <= 1'b0;
            disp_data   <= 1'b0;
            disp_valid  <= 1'b0;
        end else begin
            strobe_d <= strobes;

            if (cur_we) begin
                cur_bank[cur_widx] <= cur_wbit;
            end

            if (evo_grant) begin
                prev_status <= evo_rd_ok ? cur_bank[evo_rd_idx] : 1'b0;
            end

            // Display loses the read port to an evolution read or a copy
            // write; during clear it is answered with zero.
            disp_valid <= 1'b0;
            if (disp_rden) begin
                if (state == S_CLEAR) begin
                    disp_data  <= 1'b0;
                    disp_valid <= 1'b1;
                end else if (!evo_grant && !copy_wr) begin
                    disp_data  <= disp_ok ? cur_bank[disp_idx] : 1'b0;
                    disp_valid <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (evo_rden) begin
                        state <= S_EVOLVE;
                    end else if (clear_req) begin
                        state   <= S_CLEAR;
                        clr_idx <= '0;
                    end
                end
                S_EVOLVE: begin
                    if (evo_wden && evo_wr_ok) begin
                        nxt_bank[evo_wr_idx] <= live;
                    end
                    // The first strobe cycle still falls in S_EVOLVE; it
                    // performs the first copy read so no cell is skipped.
                    if (strobes) begin
                        copy_buf <= evo_rd_ok ? nxt_bank[evo_rd_idx] : 1'b0;
                        state    <= S_COPY;
                    end
                end
                S_COPY: begin
                    if (strobes) begin
                        copy_buf <= evo_rd_ok ? nxt_bank[evo_rd_idx] : 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    nxt_bank[clr_idx] <= 1'b0;
                    if (clr_idx == LAST_IDX) begin
                        state   <= S_IDLE;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CELL_STORE_POPCOUNT_EN
    // Bit changes are captured at the write edge and applied one cycle
    // later; clearing writes are excluded because clear forces zero.
    logic pc_up;
    logic pc_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_up      <= 1'b0;
            pc_dn      <= 1'b0;
            live_count <= '0;
        end else begin
            pc_up <= cur_we && (state != S_CLEAR) && cur_wbit && !cur_bank[cur_widx];
            pc_dn <= cur_we && (state != S_CLEAR) && !cur_wbit && cur_bank[cur_widx];
            if (state == S_CLEAR) begin
                live_count <= '0;
            end else if (pc_up) begin
                live_count <= live_count + AW'(1);
            end else if (pc_dn) begin
                live_count <= live_count - AW'(1);
            end
        end
    end
`else
    assign live_count = '0;
`endif

endmodule
